// File: rtl/seq_add.sv
// Bit-serial adder/subtractor: consumes CHUNK bits per cycle, so a result takes
// WIDTH/CHUNK cycles. Valid/ready handshake on both sides; one operation in flight.
module seq_add #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             sub,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0]   csum;
    logic             last;
    logic             msb_cin;
    int               base;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One chunk of the ripple per cycle; acc_nxt is the partial sum including this chunk.
    always_comb begin
        base    = int'(idx) * CHUNK;
        ca      = opa[base +: CHUNK];
        cb      = opb[base +: CHUNK];
        csum    = {1'b0, ca} + {1'b0, cb} + (CHUNK+1)'(carry);
        last    = (idx == IW'(STEPS - 1));
        acc_nxt = acc;
        acc_nxt[base +: CHUNK] = csum[CHUNK-1:0];
        // Sum MSB = a ^ b ^ cin, so the carry into the MSB falls out of the final sum bit.
        msb_cin = opa[WIDTH-1] ^ opb[WIDTH-1] ^ acc_nxt[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            out      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opa   <= num1;
                    opb   <= sub ? ~num2 : num2;
                    carry <= sub;
                    idx   <= '0;
                    acc   <= '0;
                end
                RUN: begin
                    acc   <= acc_nxt;
                    carry <= csum[CHUNK];
                    idx   <= idx + IW'(1);
                    if (last) begin
                        out      <= acc_nxt;
                        cout     <= csum[CHUNK];
                        overflow <= msb_cin ^ csum[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_add.sv
// Directed bench for seq_add: main configuration (8,2) plus a (W,C) sweep on
// three more instances sharing clock and reset.
module tb_seq_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] n1 [4];
    logic [15:0] n2 [4];
    logic        iv [4];
    logic        sb [4];
    logic        ordy [4];
    wire  [3:0]  rdy, vld, co, ovf;
    wire  [7:0]  o0, o1;
    wire  [15:0] o2;
    wire  [11:0] o3;
    logic [15:0] res [4];

    int n_chk = 0;
    int n_fail = 0;

    always_comb begin
        res[0] = 16'(o0);
        res[1] = 16'(o1);
        res[2] = o2;
        res[3] = 16'(o3);
    end

    seq_add #(.WIDTH(8), .CHUNK(2)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
        .num1(n1[0][7:0]), .num2(n2[0][7:0]), .sub(sb[0]), .out(o0), .cout(co[0]),
        .overflow(ovf[0]), .out_valid(vld[0]), .out_ready(ordy[0]));

    seq_add #(.WIDTH(8), .CHUNK(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
        .num1(n1[1][7:0]), .num2(n2[1][7:0]), .sub(sb[1]), .out(o1), .cout(co[1]),
        .overflow(ovf[1]), .out_valid(vld[1]), .out_ready(ordy[1]));

    seq_add #(.WIDTH(16), .CHUNK(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
        .num1(n1[2]), .num2(n2[2]), .sub(sb[2]), .out(o2), .cout(co[2]),
        .overflow(ovf[2]), .out_valid(vld[2]), .out_ready(ordy[2]));

    seq_add #(.WIDTH(12), .CHUNK(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(rdy[3]),
        .num1(n1[3][11:0]), .num2(n2[3][11:0]), .sub(sb[3]), .out(o3), .cout(co[3]),
        .overflow(ovf[3]), .out_valid(vld[3]), .out_ready(ordy[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: whole-word add of a and (possibly inverted) b.
    task automatic ref_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [15:0] r, output logic c, output logic o);
        logic [15:0] m, bb;
        logic [16:0] t;
        m  = 16'((32'd1 << w) - 1);
        bb = s ? (~b & m) : (b & m);
        t  = {1'b0, a & m} + {1'b0, bb} + 17'(s);
        r  = t[15:0] & m;
        c  = t[w];
        o  = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
    endtask

    task automatic issue(input int u, input logic [15:0] a, input logic [15:0] b, input logic s);
        chk($sformatf("u%0d_rdy", u), 32'(rdy[u]), 1);
        n1[u] = a; n2[u] = b; sb[u] = s; iv[u] = 1'b1;
        @(posedge clk); #1;
        iv[u] = 1'b0;
        chk($sformatf("u%0d_accept", u), 32'(rdy[u]), 0);
    endtask

    // Called one step after the accept edge; result must appear exactly 'steps' edges after it.
    task automatic expect_res(input int u, input int steps, input logic [15:0] eo,
                              input logic ec, input logic eov, input string tag);
        if (steps > 1) begin
            repeat (steps - 1) @(posedge clk);
            #1;
            chk({tag, "_early"}, 32'(vld[u]), 0);
        end
        @(posedge clk); #1;
        chk({tag, "_vld"},  32'(vld[u]), 1);
        chk({tag, "_out"},  32'(res[u]), 32'(eo));
        chk({tag, "_cout"}, 32'(co[u]),  32'(ec));
        chk({tag, "_ovf"},  32'(ovf[u]), 32'(eov));
    endtask

    task automatic release_out(input int u, input string tag);
        ordy[u] = 1'b1;
        @(posedge clk); #1;
        ordy[u] = 1'b0;
        chk({tag, "_vld_drop"}, 32'(vld[u]), 0);
        chk({tag, "_idle"},     32'(rdy[u]), 1);
    endtask

    task automatic run(input int u, input int steps, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] eo, input logic ec, input logic eov,
                       input string tag);
        issue(u, a, b, s);
        expect_res(u, steps, eo, ec, eov, tag);
        release_out(u, tag);
    endtask

    initial begin
        int          pulses;
        int          ws [4];
        int          st [4];
        logic [15:0] a, b, r, m;
        logic        s, c, o;
        ws = '{8, 8, 16, 12};
        st = '{4, 1, 4, 4};
        for (int i = 0; i < 4; i++) begin
            n1[i] = '0; n2[i] = '0; iv[i] = 1'b0; sb[i] = 1'b0; ordy[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out",  32'(res[0]), 0);
        chk("rst_cout", 32'(co[0]),  0);
        chk("rst_ovf",  32'(ovf[0]), 0);
        chk("rst_vld",  32'(vld),    0);
        chk("rst_rdy",  32'(rdy),    32'hF);

        run(0, 4, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, "add_ff_01");
        run(0, 4, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1, "add_7f_01");
        run(0, 4, 16'h05, 16'h07, 1'b1, 16'hFE, 1'b0, 1'b0, "sub_05_07");
        run(0, 4, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, "sub_80_01");
        run(0, 4, 16'h33, 16'h33, 1'b1, 16'h00, 1'b1, 1'b0, "sub_33_33");

        // Backpressure: hold DONE with in_valid high and noisy operands.
        issue(0, 16'h12, 16'h34, 1'b0);
        expect_res(0, 4, 16'h46, 1'b0, 1'b0, "bp");
        iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n1[0] = 16'($urandom); n2[0] = 16'($urandom); sb[0] = i[0];
            @(posedge clk); #1;
            chk("bp_hold_vld",  32'(vld[0]), 1);
            chk("bp_hold_out",  32'(res[0]), 32'h46);
            chk("bp_hold_cout", 32'(co[0]),  0);
            chk("bp_hold_ovf",  32'(ovf[0]), 0);
            chk("bp_hold_rdy",  32'(rdy[0]), 0);
        end
        n1[0] = 16'h01; n2[0] = 16'h02; sb[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp_rel_vld", 32'(vld[0]), 0);
        chk("bp_rel_rdy", 32'(rdy[0]), 1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("bp_next_accept", 32'(rdy[0]), 0);
        expect_res(0, 4, 16'h03, 1'b0, 1'b0, "bp_next");
        release_out(0, "bp_next");

        // Reset during the second RUN cycle discards the operation.
        issue(0, 16'h10, 16'h20, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out",  32'(res[0]), 0);
        chk("abort_cout", 32'(co[0]),  0);
        chk("abort_ovf",  32'(ovf[0]), 0);
        chk("abort_vld",  32'(vld[0]), 0);
        chk("abort_rdy",  32'(rdy[0]), 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (vld[0]) pulses++;
        end
        chk("abort_no_vld", 32'(pulses), 0);

        // Parameter sweep: hand vectors then random ones against the reference.
        run(1, 1, 16'h80,   16'h80,   1'b0, 16'h00,   1'b1, 1'b1, "w8c8_hand");
        run(2, 4, 16'h1234, 16'h4321, 1'b1, 16'hCF13, 1'b0, 1'b0, "w16c4_hand");
        run(3, 4, 16'h7FF,  16'h001,  1'b0, 16'h800,  1'b0, 1'b1, "w12c3_hand");
        for (int u = 1; u < 4; u++) begin
            m = 16'((32'd1 << ws[u]) - 1);
            for (int i = 0; i < 4; i++) begin
                a = 16'($urandom) & m;
                b = 16'($urandom) & m;
                s = 1'($urandom_range(1, 0));
                ref_op(ws[u], a, b, s, r, c, o);
                run(u, st[u], a, b, s, r, c, o, $sformatf("sweep_u%0d_%0d", u, i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
